// File: rtl/meduram_2w2r.sv
// Two-write / two-read register-file RAM with write- and read-collision reporting.
// Optional MEDURAM_RDCLR_EN: read outputs clear to 0 on cycles where that port's rden is low.
module meduram_2w2r #(
    parameter int ADDR_WIDTH      = 3,
    parameter int RAM_DEPTH       = 2**ADDR_WIDTH,
    parameter int DATA_WIDTH      = 8,
    parameter int WRITE_COLLISION = 1,
    parameter int READ_COLLISION  = 1
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  wren1,
    input  logic [ADDR_WIDTH-1:0] wraddr1,
    input  logic [DATA_WIDTH-1:0] wrdata1,
    input  logic                  wren2,
    input  logic [ADDR_WIDTH-1:0] wraddr2,
    input  logic [DATA_WIDTH-1:0] wrdata2,
    input  logic                  rden1,
    input  logic [ADDR_WIDTH-1:0] rdaddr1,
    output logic [DATA_WIDTH-1:0] rddata1,
    output logic [1:0]            rdcollision1,
    input  logic                  rden2,
    input  logic [ADDR_WIDTH-1:0] rdaddr2,
    output logic [DATA_WIDTH-1:0] rddata2,
    output logic [1:0]            rdcollision2
);

    localparam logic WC_EN = (WRITE_COLLISION != 0);
    localparam logic RC_EN = (READ_COLLISION != 0);

    logic [RAM_DEPTH-1:0][DATA_WIDTH-1:0] mem_q, mem_d;
    logic [RAM_DEPTH-1:0]                 wcoll_q, wcoll_d;
    logic [DATA_WIDTH-1:0]                rddata1_q, rddata1_d, rddata2_q, rddata2_d;
    logic [1:0]                           rdcoll1_q, rdcoll1_d, rdcoll2_q, rdcoll2_d;
    logic                                 wc1, wc2;

    // Port 1 is applied last so it wins a same-address write.
    always_comb begin
        mem_d   = mem_q;
        wcoll_d = wcoll_q;
        if (wren2) begin
            mem_d[wraddr2]   = wrdata2;
            wcoll_d[wraddr2] = 1'b0;
        end
        if (wren1) begin
            mem_d[wraddr1]   = wrdata1;
            wcoll_d[wraddr1] = 1'b0;
        end
        if (wren1 && wren2 && (wraddr1 == wraddr2)) begin
            wcoll_d[wraddr1] = WC_EN;
        end
    end

    assign wc1 = WC_EN & wcoll_q[rdaddr1];
    assign wc2 = WC_EN & wcoll_q[rdaddr2];

    // Reads see pre-write state; a dual read on the shared path serves rdaddr1 to both ports.
    always_comb begin
`ifdef MEDURAM_RDCLR_EN
        rddata1_d = '0;
        rdcoll1_d = '0;
        rddata2_d = '0;
        rdcoll2_d = '0;
`else
        rddata1_d = rddata1_q;
        rdcoll1_d = rdcoll1_q;
        rddata2_d = rddata2_q;
        rdcoll2_d = rdcoll2_q;
`endif
        if (RC_EN && rden1 && rden2) begin
            rddata1_d = mem_q[rdaddr1];
            rdcoll1_d = {1'b1, wc1};
            rddata2_d = mem_q[rdaddr1];
            rdcoll2_d = {1'b1, wc1};
        end else begin
            if (rden1) begin
                rddata1_d = mem_q[rdaddr1];
                rdcoll1_d = {1'b0, wc1};
            end
            if (rden2) begin
                rddata2_d = mem_q[rdaddr2];
                rdcoll2_d = {1'b0, wc2};
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            mem_q     <= '0;
            wcoll_q   <= '0;
            rddata1_q <= '0;
            rdcoll1_q <= '0;
            rddata2_q <= '0;
            rdcoll2_q <= '0;
        end else begin
            mem_q     <= mem_d;
            wcoll_q   <= wcoll_d;
            rddata1_q <= rddata1_d;
            rdcoll1_q <= rdcoll1_d;
            rddata2_q <= rddata2_d;
            rdcoll2_q <= rdcoll2_d;
        end
    end

    assign rddata1      = rddata1_q;
    assign rdcollision1 = rdcoll1_q;
    assign rddata2      = rddata2_q;
    assign rdcollision2 = rdcoll2_q;

endmodule

// File: tb/tb_meduram_2w2r.sv
// Table-driven bench for meduram_2w2r: one vector per clock, expected read results go
// through a scoreboard queue and are compared one edge later.
module tb_meduram_2w2r;

    logic       aclk = 1'b0;
    logic       areset, wren1, wren2, rden1, rden2;
    logic [2:0] wraddr1, wraddr2, rdaddr1, rdaddr2;
    logic [7:0] wrdata1, wrdata2, rddata1, rddata2;
    logic [1:0] rdcollision1, rdcollision2;

    always #5 aclk = ~aclk;

    meduram_2w2r dut (
        .aclk(aclk), .areset(areset),
        .wren1(wren1), .wraddr1(wraddr1), .wrdata1(wrdata1),
        .wren2(wren2), .wraddr2(wraddr2), .wrdata2(wrdata2),
        .rden1(rden1), .rdaddr1(rdaddr1), .rddata1(rddata1), .rdcollision1(rdcollision1),
        .rden2(rden2), .rdaddr2(rdaddr2), .rddata2(rddata2), .rdcollision2(rdcollision2)
    );

    typedef struct {
        string      n;
        bit         rst, w1, w2, r1, r2, c1, c2;
        logic [2:0] wa1, wa2, ra1, ra2;
        logic [7:0] wd1, wd2, e1, e2;
        logic [1:0] ec1, ec2;
    } vec_t;

    typedef struct {
        string      n;
        int         port;
        logic [7:0] d;
        logic [1:0] c;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

`ifdef MEDURAM_RDCLR_EN
    localparam int HOLD1 = 0;
`else
    localparam int HOLD1 = 8'h77;
`endif

    function automatic vec_t mk(input string n, input bit rst,
                                input bit w1, input int wa1, input int wd1,
                                input bit w2, input int wa2, input int wd2,
                                input bit r1, input int ra1, input bit r2, input int ra2,
                                input bit c1, input int e1, input int ec1,
                                input bit c2, input int e2, input int ec2);
        vec_t v;
        v.n = n; v.rst = rst;
        v.w1 = w1; v.wa1 = wa1[2:0]; v.wd1 = wd1[7:0];
        v.w2 = w2; v.wa2 = wa2[2:0]; v.wd2 = wd2[7:0];
        v.r1 = r1; v.ra1 = ra1[2:0]; v.r2 = r2; v.ra2 = ra2[2:0];
        v.c1 = c1; v.e1 = e1[7:0]; v.ec1 = ec1[1:0];
        v.c2 = c2; v.e2 = e2[7:0]; v.ec2 = ec2[1:0];
        return v;
    endfunction

    task automatic apply(input vec_t t);
        exp_t e;
        logic [7:0] ad;
        logic [1:0] ac;
        @(negedge aclk);
        areset = t.rst;
        wren1 = t.w1; wraddr1 = t.wa1; wrdata1 = t.wd1;
        wren2 = t.w2; wraddr2 = t.wa2; wrdata2 = t.wd2;
        rden1 = t.r1; rdaddr1 = t.ra1;
        rden2 = t.r2; rdaddr2 = t.ra2;
        if (t.c1) begin e.n = t.n; e.port = 1; e.d = t.e1; e.c = t.ec1; sb.push_back(e); end
        if (t.c2) begin e.n = t.n; e.port = 2; e.d = t.e2; e.c = t.ec2; sb.push_back(e); end
        @(posedge aclk);
        #1;
        while (sb.size() > 0) begin
            e  = sb.pop_front();
            ad = (e.port == 1) ? rddata1 : rddata2;
            ac = (e.port == 1) ? rdcollision1 : rdcollision2;
            checks++;
            if (ad !== e.d || ac !== e.c) begin
                errors++;
                $display("FAIL %s port%0d: got data=%h coll=%b, want data=%h coll=%b",
                         e.n, e.port, ad, ac, e.d, e.c);
            end
        end
    endtask

    initial begin
        areset = 1'b1; wren1 = 0; wren2 = 0; rden1 = 0; rden2 = 0;
        wraddr1 = '0; wraddr2 = '0; rdaddr1 = '0; rdaddr2 = '0; wrdata1 = '0; wrdata2 = '0;

        //         name          rst w1 wa1 wd1    w2 wa2 wd2    r1 ra1 r2 ra2  c1 e1     ec1 c2 e2     ec2
        tbl.push_back(mk("reset",      1, 0,0,0,        0,0,0,        0,0, 0,0,   1,0,0,      1,0,0));
        tbl.push_back(mk("wr1_a0",     0, 1,0,8'h5A,    0,0,0,        0,0, 0,0,   0,0,0,      0,0,0));
        tbl.push_back(mk("rd1_a0",     0, 0,0,0,        0,0,0,        1,0, 0,0,   1,8'h5A,0,  0,0,0));
        tbl.push_back(mk("wr2_a7",     0, 0,0,0,        1,7,8'hC3,    0,0, 0,0,   0,0,0,      0,0,0));
        tbl.push_back(mk("rd1_a7",     0, 0,0,0,        0,0,0,        1,7, 0,0,   1,8'hC3,0,  0,0,0));
        tbl.push_back(mk("wcoll_wr",   0, 1,3,8'h11,    1,3,8'h22,    0,0, 0,0,   0,0,0,      0,0,0));
        tbl.push_back(mk("wcoll_rd",   0, 0,0,0,        0,0,0,        1,3, 0,0,   1,8'h11,1,  0,0,0));
        tbl.push_back(mk("wcoll_clrw", 0, 1,3,8'h33,    0,0,0,        0,0, 0,0,   0,0,0,      0,0,0));
        tbl.push_back(mk("wcoll_clrr", 0, 0,0,0,        0,0,0,        0,0, 1,3,   0,0,0,      1,8'h33,0));
        tbl.push_back(mk("wr_a4",      0, 1,4,8'hA5,    0,0,0,        0,0, 0,0,   0,0,0,      0,0,0));
        tbl.push_back(mk("rcoll_same", 0, 0,0,0,        0,0,0,        1,4, 1,4,   1,8'hA5,2,  1,8'hA5,2));
        tbl.push_back(mk("wr_a2_a3",   0, 1,2,8'h10,    1,3,8'h20,    0,0, 0,0,   0,0,0,      0,0,0));
        tbl.push_back(mk("rcoll_diff", 0, 0,0,0,        0,0,0,        1,2, 1,3,   1,8'h10,2,  1,8'h10,2));
        tbl.push_back(mk("seq_rd_a2",  0, 0,0,0,        0,0,0,        1,2, 0,0,   1,8'h10,0,  0,0,0));
        tbl.push_back(mk("seq_rd_a3",  0, 0,0,0,        0,0,0,        0,0, 1,3,   0,0,0,      1,8'h20,0));
        tbl.push_back(mk("rdw_old",    0, 1,5,8'h77,    0,0,0,        1,5, 0,0,   1,0,0,      0,0,0));
        tbl.push_back(mk("rdw_new",    0, 0,0,0,        0,0,0,        1,5, 0,0,   1,8'h77,0,  0,0,0));
        tbl.push_back(mk("idle_hold",  0, 0,0,0,        0,0,0,        0,0, 0,0,   1,HOLD1,0,  0,0,0));
        tbl.push_back(mk("wcoll_a6",   0, 1,6,8'h55,    1,6,8'h66,    0,0, 0,0,   0,0,0,      0,0,0));
        tbl.push_back(mk("rcoll_wc",   0, 0,0,0,        0,0,0,        1,6, 1,1,   1,8'h55,3,  1,8'h55,3));
        tbl.push_back(mk("rdw_oldwc",  0, 1,6,8'h99,    0,0,0,        0,0, 1,6,   0,0,0,      1,8'h55,1));
        tbl.push_back(mk("rdw_newwc",  0, 0,0,0,        0,0,0,        0,0, 1,6,   0,0,0,      1,8'h99,0));
        tbl.push_back(mk("pre_rst",    0, 1,1,8'hEE,    1,1,8'hDD,    0,0, 0,0,   0,0,0,      0,0,0));
        tbl.push_back(mk("mid_rst",    1, 1,2,8'hFF,    0,0,0,        1,1, 0,0,   1,0,0,      1,0,0));
        tbl.push_back(mk("post_rst_a1",0, 0,0,0,        0,0,0,        1,1, 0,0,   1,0,0,      0,0,0));
        tbl.push_back(mk("post_rst_a2",0, 0,0,0,        0,0,0,        0,0, 1,2,   0,0,0,      1,0,0));

        // Sweep: every address, all write/read agent pairings, random data.
        for (int p = 0; p < 4; p++) begin
            for (int a = 0; a < 8; a++) begin
                int  d;
                bit  wp2, rp2;
                d   = int'($urandom_range(0, 255));
                wp2 = p[0];
                rp2 = p[1];
                tbl.push_back(mk("sweep_wr", 0, !wp2,a,d, wp2,a,d, 0,0, 0,0, 0,0,0, 0,0,0));
                tbl.push_back(mk("sweep_rd", 0, 0,0,0, 0,0,0, !rp2,a, rp2,a,
                                 !rp2,d,0, rp2,d,0));
            end
        end

        foreach (tbl[i]) apply(tbl[i]);

        @(negedge aclk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
